// File: rtl/pc_branch_pkg.sv
// Shared types for the branch unit: control opcodes, FSM states and the
// default sequential PC step.
package pc_branch_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_COM  = 4'b0001,
    OP_END  = 4'b0010,
    OP_CALL = 4'b1000,
    OP_RET  = 4'b1001,
    OP_JMP  = 4'b1100,
    OP_JEQ  = 4'b1101,
    OP_JLT  = 4'b1110,
    OP_JNE  = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_COM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_STEP = 32'd4;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack. The pointer counts 0..DEPTH, so exactly DEPTH pushes
// fit. A push when full or a pop when empty is dropped; the caller flags it.
module ret_stack #(
  parameter int I     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [I-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [I-1:0] top
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   SP_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IX_ONE  = AW'(1);

  logic [AW:0]   sp_q, sp_d;
  logic [I-1:0]  mem_q [DEPTH];
  logic [I-1:0]  mem_d [DEPTH];
  logic [AW-1:0] top_idx;

  assign full    = (sp_q == SP_FULL);
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q[AW-1:0] - IX_ONE;
  assign top     = mem_q[top_idx];

  // Pointer and storage update
  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (push && !full) begin
      mem_d[sp_q[AW-1:0]] = push_data;
      sp_d                = sp_q + SP_ONE;
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_ONE;
    end else begin
      sp_d = sp_q;
    end
  end

  // Stack state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter sequencer: sequential fetch, absolute jumps, flag-conditional
// branches, CALL/RET through a return stack, and a COM handshake with an interpreter.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter int I     = 32,
  parameter int N     = 8,
  parameter int STEP  = DEFAULT_STEP,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         FlagsWrite,
  input  logic [1:0]   ALUFlags,
  input  logic [3:0]   Id,
  input  logic [N-1:0] Imm,
  input  logic         com_ack,
  output logic [I-1:0] PCNext,
  output logic         EndFlag,
  output logic         COMFlag,
  output logic         StackErr,
  output logic         Busy
);

  localparam logic [I-1:0] STEP_I = I'(STEP);

  state_e       state_q, state_d;
  logic [I-1:0] pc_q, pc_d;
  logic [1:0]   flags_q, flags_d;
  logic         err_q, err_d;
  logic         push_s, pop_s, full_s, empty_s;
  logic [I-1:0] top_s, pc_step_s, imm_ext_s;

  assign pc_step_s = pc_q + STEP_I;
  assign imm_ext_s = I'(Imm);

  ret_stack #(.I(I), .DEPTH(DEPTH)) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_step_s),
    .full      (full_s),
    .empty     (empty_s),
    .top       (top_s)
  );

  // Next-state, next-PC and stack control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    // Branches below read flags_q, so a same-cycle FlagsWrite is not yet visible.
    flags_d = FlagsWrite ? ALUFlags : flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        case (opcode_e'(Id))
          OP_NOP: pc_d = pc_step_s;
          OP_COM: begin
            pc_d    = pc_step_s;
            state_d = ST_COM_WAIT;
          end
          OP_END: state_d = ST_HALT;
          OP_CALL: begin
            if (full_s) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              push_s = 1'b1;
              pc_d   = imm_ext_s;
            end
          end
          OP_RET: begin
            if (empty_s) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pop_s = 1'b1;
              pc_d  = top_s;
            end
          end
          OP_JMP:  pc_d = imm_ext_s;
          OP_JEQ:  pc_d = flags_q[0]  ? imm_ext_s : pc_step_s;
          OP_JLT:  pc_d = flags_q[1]  ? imm_ext_s : pc_step_s;
          OP_JNE:  pc_d = !flags_q[0] ? imm_ext_s : pc_step_s;
          default: pc_d = pc_step_s;
        endcase
      end
      ST_COM_WAIT: begin
        if (com_ack) state_d = ST_RUN;
        else         state_d = ST_COM_WAIT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      flags_q <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign PCNext   = pc_q;
  assign EndFlag  = (state_q == ST_HALT);
  assign COMFlag  = (state_q == ST_COM_WAIT);
  assign StackErr = err_q;
  assign Busy     = (state_q == ST_RUN) || (state_q == ST_COM_WAIT);

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter I, default 32, PC width in bits.
REQ-002 Parameter N, default 8, branch immediate width in bits.
REQ-003 Parameter STEP, default 4, sequential PC increment.
REQ-004 Parameter DEPTH, default 4, return-stack entries (power of two, >=2).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; leaves IDLE and begins fetching.
REQ-008 FlagsWrite  in  1  captures ALUFlags into flag register.
REQ-009 ALUFlags  in  2  bit0 = equal/zero, bit1 = less-than.
REQ-010 Id  in  4  control opcode of current instruction.
REQ-011 Imm  in  N  absolute branch target, zero-extended to I bits.
REQ-012 com_ack  in  1  interpreter acknowledge for COM.
REQ-013 PCNext  out  I  registered program counter.
REQ-014 EndFlag  out  1  high while in HALT.
REQ-015 COMFlag  out  1  high while in COM_WAIT.
REQ-016 StackErr  out  1  sticky return-stack overflow/underflow.
REQ-017 Busy  out  1  high in RUN or COM_WAIT.

Function
REQ-018 FSM states SHALL be IDLE, RUN, COM_WAIT, HALT; PCNext SHALL hold in every state except RUN.
REQ-019 IDLE -> RUN when start=1; PCNext stays 0 in IDLE.
REQ-020 In RUN, opcodes: 0000 NOP, PC+STEP; 0001 COM, PC+STEP and -> COM_WAIT; 0010 END, PC held and -> HALT; 1000 CALL, push PC+STEP, PC=Imm; 1001 RET, PC=pop; 1100 JMP, PC=Imm; 1101 JEQ, Imm if flag0 else PC+STEP; 1110 JLT, Imm if flag1 else PC+STEP; 1111 JNE, Imm if !flag0 else PC+STEP; all others PC+STEP.
REQ-021 Branch conditions SHALL use the registered flags; FlagsWrite and a conditional branch in the same cycle use the old flags.
REQ-022 PC arithmetic SHALL wrap modulo 2^I.
REQ-023 COM_WAIT -> RUN on the cycle com_ack=1; no PC update on that cycle; com_ack outside COM_WAIT is ignored.
REQ-024 CALL with stack full or RET with stack empty SHALL set StackErr, leave PCNext unchanged and go to HALT.
REQ-025 HALT SHALL be left only by reset; start, Id and com_ack are ignored there.
REQ-026 Latency: PCNext reflects a RUN-state opcode one clock after it is presented.
REQ-027 Stack pointer SHALL count 0..DEPTH; exactly DEPTH nested CALLs succeed.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, PCNext=0, flags=00, stack pointer=0, StackErr=0; the outputs derived from these values are EndFlag=0, COMFlag=0 and Busy=0.
REQ-029 Reset SHALL override start, FlagsWrite and com_ack in the same cycle and abort COM_WAIT or HALT.

Structure
REQ-030 Shared package pc_branch_pkg SHALL hold the opcode enum (4-bit), the FSM state enum and the default STEP constant.
REQ-031 Return stack SHALL be sub-module ret_stack (parameters I, DEPTH; push, pop, full, empty, top), synchronous reset.

Verification
REQ-032 reset, start=1, Id=0000 for 3 cycles -> PCNext 0,4,8,12; Busy=1.
REQ-033 FlagsWrite=1 with ALUFlags=01, then Id=1101 with Imm=0x40 -> PCNext=0x40; with ALUFlags=00 -> PC+4.
REQ-034 Id=0001 at PC=8 -> PCNext=12, COMFlag=1 and PC held 5 cycles; com_ack=1 -> COMFlag=0 and the next NOP gives PCNext=16.
REQ-035 At PC=0x10, CALL Imm=0x80 then RET -> PCNext 0x80 then 0x14; 5 nested CALLs with DEPTH=4 -> StackErr=1, EndFlag=1 and PC held.
REQ-036 I=8, PC=0xFC, NOP -> PCNext=0x00.
REQ-037 Id=0010 -> EndFlag=1 and PC frozen while start=1 and Id=1100 are applied; reset=1 -> PCNext=0 and state IDLE.
